// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
// Provides the BTB 2-bit counter encoding, the BTB entry record, the reset PC and the PC step.
// Ports: none (package). Optional BTB is enabled by defining FETCH_BTB_EN.
package fetch_pkg;

  localparam int unsigned DBITS_DEF      = 32;
  localparam int unsigned INSTBITS_DEF   = 32;
  localparam int unsigned INSTSIZE_DEF   = 4;
  localparam int unsigned BTBIDXBITS_DEF = 4;
  localparam logic [31:0] STARTPC_DEF    = 32'h100;

  // Storage width for the tag and target fields of a BTB entry; narrower
  // tags are zero-extended into it.
  localparam int unsigned BTB_ADDR_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                  valid;
    logic [BTB_ADDR_W-1:0] tag;
    logic [BTB_ADDR_W-1:0] target;
    ctr_t                  ctr;
  } btb_entry_t;

  // Saturating 2-bit counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// btb: direct-mapped branch target buffer with 2-bit saturating counters.
// Ports: clk/RESET_N (sync active-low clear of valid+counters), lookup_wpc -> pred_taken/pred_target
// (combinational, sees pre-update contents), upd_* (synchronous training). Word addresses (PC>>2) in.
module btb
  import fetch_pkg::*;
#(
  parameter int DBITS   = 32,
  parameter int IDXBITS = 4
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [DBITS-3:0] lookup_wpc,
  output logic             pred_taken,
  output logic [DBITS-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [DBITS-3:0] upd_wpc,
  input  logic             upd_taken,
  input  logic [DBITS-1:0] upd_target
);

  localparam int ENTRIES = 1 << IDXBITS;
  localparam int TAGW    = DBITS - 2 - IDXBITS;

  btb_entry_t tbl [ENTRIES];

  logic [IDXBITS-1:0] lk_idx, up_idx;
  logic [TAGW-1:0]    lk_tag, up_tag;
  btb_entry_t         lk_e, up_e;
  logic               lk_hit, up_hit;

  assign lk_idx = lookup_wpc[IDXBITS-1:0];
  assign lk_tag = lookup_wpc[DBITS-3:IDXBITS];
  assign up_idx = upd_wpc[IDXBITS-1:0];
  assign up_tag = upd_wpc[DBITS-3:IDXBITS];

  assign lk_e = tbl[lk_idx];
  assign up_e = tbl[up_idx];

  assign lk_hit = lk_e.valid && (lk_e.tag == BTB_ADDR_W'(lk_tag));
  assign up_hit = up_e.valid && (up_e.tag == BTB_ADDR_W'(up_tag));

  // Predict taken only from the upper half of the counter range.
  assign pred_taken  = lk_hit && lk_e.ctr[1];
  assign pred_target = lk_e.target[DBITS-1:0];

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= SNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        tbl[up_idx].ctr <= ctr_next(up_e.ctr, upd_taken);
        if (upd_taken) tbl[up_idx].target <= BTB_ADDR_W'(upd_target);
      end else if (upd_taken) begin
        // Miss on a taken branch: allocate, evicting whatever aliased here.
        tbl[up_idx] <= '{valid:  1'b1,
                         tag:    BTB_ADDR_W'(up_tag),
                         target: BTB_ADDR_W'(upd_target),
                         ctr:    WT};
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, I-MEM address, next-PC prediction and FE/ID latch.
// Ports: stall holds PC+latch; mispred/pcgood redirect (one bubble); imem_addr/imem_data async I-MEM;
// bpupd_* trains the BTB; *_FE latch outputs. BTB present only when FETCH_BTB_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               DBITS      = DBITS_DEF,
  parameter int               INSTBITS   = INSTBITS_DEF,
  parameter int               INSTSIZE   = INSTSIZE_DEF,
  parameter logic [DBITS-1:0] STARTPC    = STARTPC_DEF,
  parameter int               BTBIDXBITS = BTBIDXBITS_DEF
) (
  input  logic                clk,
  input  logic                RESET_N,
  input  logic                stall,
  input  logic                mispred,
  input  logic [DBITS-1:0]    pcgood,
  output logic [DBITS-1:0]    imem_addr,
  input  logic [INSTBITS-1:0] imem_data,
  input  logic                bpupd_valid,
  input  logic [DBITS-1:0]    bpupd_pc,
  input  logic                bpupd_taken,
  input  logic [DBITS-1:0]    bpupd_target,
  output logic                valid_FE,
  output logic [INSTBITS-1:0] inst_FE,
  output logic [DBITS-1:0]    pc_FE,
  output logic [DBITS-1:0]    pcpred_FE
);

  logic [DBITS-1:0] pc;
  logic [DBITS-1:0] pcplus;
  logic [DBITS-1:0] pcpred;

  assign imem_addr = pc;
  assign pcplus    = pc + DBITS'(INSTSIZE);

`ifdef FETCH_BTB_EN
  logic             btb_taken;
  logic [DBITS-1:0] btb_target;
  logic             unused_upd_lsb;

  assign unused_upd_lsb = ^bpupd_pc[1:0];

  btb #(
    .DBITS   (DBITS),
    .IDXBITS (BTBIDXBITS)
  ) u_btb (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .lookup_wpc  (pc[DBITS-1:2]),
    .pred_taken  (btb_taken),
    .pred_target (btb_target),
    .upd_valid   (bpupd_valid),
    .upd_wpc     (bpupd_pc[DBITS-1:2]),
    .upd_taken   (bpupd_taken),
    .upd_target  (bpupd_target)
  );

  assign pcpred = btb_taken ? btb_target : pcplus;
`else
  logic unused_bpupd;

  assign unused_bpupd = ^{bpupd_valid, bpupd_pc, bpupd_taken, bpupd_target, 1'(BTBIDXBITS)};
  assign pcpred       = pcplus;
`endif

  // PC: reset > redirect > stall > predicted next.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      pc <= STARTPC;
    end else if (mispred) begin
      pc <= pcgood;
    end else if (!stall) begin
      pc <= pcpred;
    end
  end

  // FE/ID latch. A redirect squashes the fetched word even under stall, since
  // the PC it came from is on the wrong path; pc_FE/pcpred_FE are left as-is
  // because a bubble's PC fields are don't-care downstream.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      valid_FE  <= 1'b0;
      inst_FE   <= '0;
      pc_FE     <= '0;
      pcpred_FE <= '0;
    end else if (mispred) begin
      valid_FE <= 1'b0;
      inst_FE  <= '0;
    end else if (!stall) begin
      valid_FE  <= 1'b1;
      inst_FE   <= imem_data;
      pc_FE     <= pc;
      pcpred_FE <= pcpred;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (FETCH_BTB_EN selects expected predictions).
// Table-driven reset/stall/redirect vectors, hand sequences for BTB training, saturation,
// aliasing and reset, then randomized traffic against an array-based reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        stall;
  logic        mispred;
  logic [31:0] pcgood;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        bpupd_valid;
  logic [31:0] bpupd_pc;
  logic        bpupd_taken;
  logic [31:0] bpupd_target;
  logic        valid_FE;
  logic [31:0] inst_FE;
  logic [31:0] pc_FE;
  logic [31:0] pcpred_FE;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  assign imem_data = imem_fn(imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .RESET_N      (RESET_N),
    .stall        (stall),
    .mispred      (mispred),
    .pcgood       (pcgood),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .bpupd_valid  (bpupd_valid),
    .bpupd_pc     (bpupd_pc),
    .bpupd_taken  (bpupd_taken),
    .bpupd_target (bpupd_target),
    .valid_FE     (valid_FE),
    .inst_FE      (inst_FE),
    .pc_FE        (pc_FE),
    .pcpred_FE    (pcpred_FE)
  );

  // Reference model: plain integers, 16-entry table, counter as 0..3.
  logic [31:0] m_pc, m_inst, m_pcfe, m_pcpredfe;
  bit          m_valid;
  bit          bv   [16];
  logic [31:0] btag [16];
  logic [31:0] btgt [16];
  int          bctr [16];

  function automatic logic [31:0] m_predict(input logic [31:0] pc);
    int idx;
    idx = int'((pc / 4) % 16);
    if (BTB_ON && bv[idx] && btag[idx] == pc / 64 && bctr[idx] >= 2) return btgt[idx];
    return pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit m, input logic [31:0] pg,
                       input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    logic [31:0] pred;
    int idx;
    @(negedge clk);
    RESET_N = r; stall = s; mispred = m; pcgood = pg;
    bpupd_valid = uv; bpupd_pc = upc; bpupd_taken = ut; bpupd_target = utg;
    pred = m_predict(m_pc);
    if (!r) begin
      m_pc = 32'h100; m_valid = 0; m_inst = 0; m_pcfe = 0; m_pcpredfe = 0;
      for (int i = 0; i < 16; i++) begin bv[i] = 0; bctr[i] = 0; end
    end else begin
      if (m) begin
        m_valid = 0; m_inst = 0;
      end else if (!s) begin
        m_valid = 1; m_inst = imem_fn(m_pc); m_pcfe = m_pc; m_pcpredfe = pred;
      end
      m_pc = m ? pg : (s ? m_pc : pred);
      if (uv && BTB_ON) begin
        idx = int'((upc / 4) % 16);
        if (bv[idx] && btag[idx] == upc / 64) begin
          bctr[idx] = ut ? ((bctr[idx] == 3) ? 3 : bctr[idx] + 1)
                         : ((bctr[idx] == 0) ? 0 : bctr[idx] - 1);
          if (ut) btgt[idx] = utg;
        end else if (ut) begin
          bv[idx] = 1; btag[idx] = upc / 64; btgt[idx] = utg; bctr[idx] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    check("model_imem_addr", imem_addr, m_pc);
    check("model_valid_FE", {31'd0, valid_FE}, {31'd0, m_valid});
    check("model_inst_FE", inst_FE, m_inst);
    if (m_valid) begin
      check("model_pc_FE", pc_FE, m_pcfe);
      check("model_pcpred_FE", pcpred_FE, m_pcpredfe);
    end
  endtask

  task automatic idle(input bit r, input bit s, input bit m, input logic [31:0] pg);
    cycle(r, s, m, pg, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, pc, t, tg);
  endtask

  // Redirect to pc, let it fetch once, and check what was predicted for it.
  task automatic probe(input string name, input logic [31:0] pc, input logic [31:0] exp);
    idle(1'b1, 1'b0, 1'b1, pc);
    idle(1'b1, 1'b0, 1'b0, 32'd0);
    check({name, "_addr"}, imem_addr, exp);
    check({name, "_pc_FE"}, pc_FE, pc);
    check({name, "_pcpred_FE"}, pcpred_FE, exp);
  endtask

  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          mispred;
    logic [31:0] pcgood;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pcfe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] pool [8];
    RESET_N = 0; stall = 0; mispred = 0; pcgood = 0;
    bpupd_valid = 0; bpupd_pc = 0; bpupd_taken = 0; bpupd_target = 0;

    vecs[0] = '{0, 0, 0, 32'h000, 32'h100, 0, 32'h000};
    vecs[1] = '{0, 0, 0, 32'h000, 32'h100, 0, 32'h000};
    vecs[2] = '{1, 0, 0, 32'h000, 32'h104, 1, 32'h100};
    vecs[3] = '{1, 0, 0, 32'h000, 32'h108, 1, 32'h104};
    vecs[4] = '{1, 1, 0, 32'h000, 32'h108, 1, 32'h104};
    vecs[5] = '{1, 1, 0, 32'h000, 32'h108, 1, 32'h104};
    vecs[6] = '{1, 1, 0, 32'h000, 32'h108, 1, 32'h104};
    vecs[7] = '{1, 0, 0, 32'h000, 32'h10c, 1, 32'h108};
    vecs[8] = '{1, 1, 1, 32'h200, 32'h200, 0, 32'h000};
    vecs[9] = '{1, 0, 0, 32'h000, 32'h204, 1, 32'h200};

    for (int i = 0; i < 10; i++) begin
      idle(vecs[i].rst_n, vecs[i].stall, vecs[i].mispred, vecs[i].pcgood);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'd0, valid_FE}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_inst", i), inst_FE,
            vecs[i].exp_valid ? imem_fn(vecs[i].exp_pcfe) : 32'd0);
      if (vecs[i].exp_valid || !vecs[i].rst_n)
        check($sformatf("vec%0d_pc_FE", i), pc_FE, vecs[i].exp_pcfe);
    end

    // Training and counter saturation on 0x120.
    train(32'h120, 1, 32'h180);
    probe("alloc", 32'h120, BTB_ON ? 32'h180 : 32'h124);
    for (int k = 0; k < 3; k++) begin
      train(32'h120, 0, 32'h0);
      probe($sformatf("nt%0d", k), 32'h120, 32'h124);
    end
    train(32'h120, 1, 32'h180);
    probe("t_from_snt", 32'h120, 32'h124);
    train(32'h120, 1, 32'h180);
    probe("t_to_wt", 32'h120, BTB_ON ? 32'h180 : 32'h124);

    // Alias 0x160 evicts 0x120; mid-run reset clears the table.
    train(32'h160, 1, 32'h300);
    probe("alias_old", 32'h120, 32'h124);
    probe("alias_new", 32'h160, BTB_ON ? 32'h300 : 32'h164);
    idle(1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b0, 1'b0, 32'd0);
    probe("post_reset", 32'h160, 32'h164);

    // Same-cycle lookup sees the old entry; the next lookup sees the new one.
    idle(1'b1, 1'b0, 1'b1, 32'h160);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h160, 1'b1, 32'h300);
    check("same_cycle_addr", imem_addr, 32'h164);
    probe("after_write", 32'h160, BTB_ON ? 32'h300 : 32'h164);

    // PC increment wraps at the top of the address space.
    probe("wrap", 32'hFFFF_FFFC, 32'h0);

    // Randomized traffic; small address pool so hits, aliases and retrains occur.
    pool = '{32'h100, 32'h120, 32'h160, 32'h1120, 32'h13c, 32'h17c, 32'h200, 32'h240};
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pg, upc, utg;
      pg  = pool[$urandom_range(0, 7)] + 32'(4 * $urandom_range(0, 3));
      upc = pool[$urandom_range(0, 7)];
      utg = pool[$urandom_range(0, 7)] + 32'h40;
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), pg,
            ($urandom_range(0, 2) == 0), upc, ($urandom_range(0, 2) != 0), utg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of decode. Owns the PC register, drives the asynchronous-read instruction memory, and loads the FE/ID latch (instruction, its PC, its predicted next PC). It predicts next-PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, trained by execute. It accepts a stall from decode and a redirect from execute.

## Interface
- DBITS, 32, data/address width
- INSTBITS, 32, instruction width
- INSTSIZE, 4, PC increment in bytes
- STARTPC, 32'h100, PC after reset
- BTBIDXBITS, 4, log2 of BTB entries (16)
- clk  in  1  pipeline clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- stall  in  1  hold PC and FE latch (decode hazard)
- mispred  in  1  redirect from execute
- pcgood  in  DBITS  correct next PC when mispred
- imem_addr  out  DBITS  byte address to I-MEM, equals PC register
- imem_data  in  INSTBITS  I-MEM word, combinational from imem_addr
- bpupd_valid  in  1  execute resolved a branch/JAL this cycle
- bpupd_pc  in  DBITS  PC of resolved instruction
- bpupd_taken  in  1  resolved direction
- bpupd_target  in  DBITS  resolved taken target
- valid_FE  out  1  FE latch holds a real instruction
- inst_FE  out  INSTBITS  latched instruction
- pc_FE  out  DBITS  PC of inst_FE
- pcpred_FE  out  DBITS  predicted next PC of inst_FE (execute compares against it)

## Operation
- PC update priority: RESET_N low > mispred > stall > advance to pcpred.
- pcplus = PC + INSTSIZE, modulo 2^DBITS (wraps, no flag).
- BTB index = PC[BTBIDXBITS+1:2]; tag = PC[DBITS-1:BTBIDXBITS+2]. Entry = valid, tag, target, ctr[1:0].
- Lookup (combinational): hit = valid && tag match. pcpred = target when hit && ctr[1]; otherwise pcpred = pcplus.
- Update on bpupd_valid, indexed and tagged by bpupd_pc:
  - hit: ctr saturating +1 if taken, -1 if not; target overwritten only if taken.
  - miss and taken: allocate (valid=1, tag, target, ctr=2'b10), replacing any alias.
  - miss and not taken: no change.
- Updates proceed regardless of stall or mispred.
- FE latch:
  - reset: valid_FE=0, inst_FE=0, pc_FE=0, pcpred_FE=0.
  - mispred: bubble (valid_FE=0, inst_FE=0), even if stall is also high.
  - stall only: hold all four outputs.
  - otherwise: load valid=1, imem_data, PC, pcpred.
- Reset clears all BTB valid bits and counters, including mid-run.

## Timing
- I-MEM read is zero-latency. imem_addr comes straight from the PC register.
- Fetch latency: instruction at PC appears on inst_FE one edge after PC is presented.
- Redirect: mispred sampled at edge N gives PC=pcgood after N. The correct instruction reaches inst_FE after N+1, so exactly one bubble.
- A BTB write on edge N is visible to lookups from the cycle after N. A same-cycle lookup of the same index sees old contents.
- No combinational path from any input to any output except imem_data → next-state logic.

## Configuration
- FETCH_BTB_EN defined: BTB and prediction as above.
- FETCH_BTB_EN undefined: no BTB storage; pcpred = pcplus always; bpupd_* ignored. All other behaviour and timing are identical.

## Structure
- Package fetch_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - BTB entry typedef
  - STARTPC and INSTSIZE defaults
- Sub-module btb: combinational lookup port, synchronous update port, synchronous clear on RESET_N. It is instantiated only under FETCH_BTB_EN.

## Test plan
- Reset: RESET_N low 2 cycles → imem_addr=0x100, valid_FE=0, inst_FE=0. After release, imem_addr steps 0x100, 0x104, 0x108, and pc_FE trails by one cycle.
- Stall: stall high 3 cycles with PC=0x108 → imem_addr stays 0x108. inst_FE/pc_FE hold 0x104's word, then advance one edge after stall drops.
- Redirect during stall: stall=1, mispred=1, pcgood=0x200 → next imem_addr=0x200 and valid_FE=0. Next edge: pc_FE=0x200, valid_FE=1.
- Training: update pc=0x120, taken, target=0x180 → when PC=0x120, next imem_addr=0x180 and pcpred_FE=0x180 alongside pc_FE=0x120.
- Saturation: starting from allocation above, apply in turn:
  - 3× not-taken → ctr 01, 00, 00, prediction 0x124.
  - then 1× taken → ctr 01, still 0x124.
  - then 1× taken → ctr 10, predicts 0x180.
- Aliasing and reset: taken update pc=0x160 target=0x300 (same index as 0x120) → 0x120 now predicts 0x124. A mid-run reset then makes 0x160 predict 0x164.
